// File: rtl/sram_prog_pkg.sv
// sram_prog_pkg
// Shared definitions for the bit-line/word-line programming controller:
// the controller state encoding, the default phase lengths and a small
// helper used to size the shared phase counter.
package sram_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SETUP,
    PULSE,
    HOLD,
    DONE
  } state_e;

  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  // Longest of the three phase lengths; the shared counter must hold it.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_prog_phase_timer.sv
// sram_prog_phase_timer
// Loadable down-counter that times the SETUP, PULSE and HOLD phases.
// Loading N-1 on phase entry makes expired_o assert in the N-th cycle of
// the phase, which is the cycle in which the controller leaves it.
// Ports:
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   load_i     in  load load_val_i into the counter this edge
//   load_val_i in  CW  value to load (phase length minus one)
//   expired_o  out counter has reached zero
module sram_prog_phase_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          expired_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Load wins over counting; the counter parks at zero once it gets there.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sram_blwl_prog.sv
// sram_blwl_prog
// Write-side driver for a NUM_WL x NUM_BL bank of sram6T_blwl cells.
// After start it accepts one row per in_valid/in_ready handshake, drives the
// row onto bl, then pulses exactly one wl line so the row latches bl.
// Ports:
//   clk       in  clock
//   rst       in  synchronous active-high reset
//   start     in  begin a full-bank pass (only looked at in IDLE)
//   in_data   in  NUM_BL  row data, bit i drives bl[i]
//   in_valid  in  in_data valid
//   in_ready  out controller can accept a row (WAIT_DATA only)
//   bl        out NUM_BL  bit-line drive
//   wl        out NUM_WL  word-line drive, one-hot or all-zero
//   row       out RW      row currently being programmed
//   busy      out pass in progress
//   done      out one-cycle pulse after the last row
// Every output is a flop; the next-cycle output values are decoded from the
// next state so no input reaches an output combinationally.
module sram_blwl_prog
  import sram_prog_pkg::*;
#(
  parameter int NUM_BL    = 8,
  parameter int NUM_WL    = 8,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  localparam int RW       = (NUM_WL > 1) ? $clog2(NUM_WL) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_BL-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NUM_BL-1:0] bl,
  output logic [NUM_WL-1:0] wl,
  output logic [RW-1:0]     row,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam logic [CW-1:0]     SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0]     PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0]     HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [RW-1:0]     LAST_ROW = RW'(NUM_WL - 1);
  localparam logic [NUM_WL-1:0] WL_ONE   = NUM_WL'(1);

  state_e              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [NUM_BL-1:0]   bl_q, bl_d;
  logic [NUM_WL-1:0]   wl_q, wl_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tmr_load;
  logic [CW-1:0]       tmr_load_val;
  logic                tmr_expired;

  sram_prog_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .expired_o  (tmr_expired)
  );

  // Next-state logic. bl only ever changes on row acceptance (wl is low
  // then and stays low through SETUP) or when leaving DONE, so it can never
  // move under a high word-line.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    bl_d         = bl_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          row_d   = '0;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (in_valid && in_ready_q) begin
          bl_d         = in_data;
          state_d      = SETUP;
          tmr_load     = 1'b1;
          tmr_load_val = SETUP_LD;
        end
      end
      SETUP: begin
        if (tmr_expired) begin
          state_d      = PULSE;
          tmr_load     = 1'b1;
          tmr_load_val = PULSE_LD;
        end
      end
      PULSE: begin
        if (tmr_expired) begin
          state_d      = HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = HOLD_LD;
        end
      end
      HOLD: begin
        if (tmr_expired) begin
          if (row_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = WAIT_DATA;
          end
        end
      end
      DONE: begin
        bl_d    = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    wl_d       = (state_d == PULSE) ? (WL_ONE << row_q) : '0;
    in_ready_d = (state_d == WAIT_DATA);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      bl_q       <= '0;
      wl_q       <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      bl_q       <= bl_d;
      wl_q       <= wl_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign bl       = bl_q;
  assign wl       = wl_q;
  assign row      = row_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sram_blwl_prog.sv
// tb_sram_blwl_prog
// Bench for the bit-line/word-line programming controller. The driver pushes
// the expected word-line pulse (row, data, rise cycle) for every accepted row
// into a queue; a monitor pops it on each observed wl rise and also keeps a
// behavioural 8x8 sram6T_blwl bank that latches bl on each wl rising edge.
// A second instance checks the single-row, long-setup configuration.
module tb_sram_blwl_prog;

  localparam int NBL = 8;
  localparam int NWL = 8;
  localparam int S   = 1;
  localparam int P   = 2;
  localparam int H   = 1;

  typedef struct {
    int         rowIdx;
    logic [7:0] data;
    int         rise;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [NBL-1:0] in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [NBL-1:0] bl;
  logic [NWL-1:0] wl;
  logic [2:0]     row;
  logic           busy;
  logic           done;

  logic           c_start = 1'b0;
  logic [7:0]     c_data = '0;
  logic           c_valid = 1'b0;
  logic           c_ready;
  logic [7:0]     c_bl;
  logic [0:0]     c_wl;
  logic [0:0]     c_row;
  logic           c_busy;
  logic           c_done;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   rowCnt = 0;
  exp_t expQ[$];
  int   doneQ[$];
  logic [7:0] bank [NWL];
  logic [7:0] passData [NWL];

  sram_blwl_prog dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .bl(bl), .wl(wl),
    .row(row), .busy(busy), .done(done)
  );

  sram_blwl_prog #(
    .NUM_BL(8), .NUM_WL(1), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)
  ) dut1row (
    .clk(clk), .rst(rst), .start(c_start), .in_data(c_data),
    .in_valid(c_valid), .in_ready(c_ready), .bl(c_bl), .wl(c_wl),
    .row(c_row), .busy(c_busy), .done(c_done)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the index of the latest rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string nm, input logic [63:0] act,
                             input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               nm, act, expv, cyc);
    end
  endtask

  // Monitor: scoreboard pops, word-line shape rules and the cell bank model.
  logic [NWL-1:0] prevWl = '0;
  logic [NBL-1:0] prevBl = '0;
  exp_t           cur;
  int             riseCyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      prevWl = '0;
    end else begin
      checkOutput("wl_onehot0", 64'($onehot0(wl)), 64'd1);
      if (prevWl != '0 && wl != '0) begin
        checkOutput("bl_stable_under_wl", 64'(bl), 64'(prevBl));
        checkOutput("wl_same_line", 64'(wl), 64'(prevWl));
      end
      if (prevWl == '0 && wl != '0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_wl_rise", 64'(wl), 64'd0);
        end else begin
          cur = expQ.pop_front();
          riseCyc = cyc;
          checkOutput("wl_rise_cycle", 64'(cyc), 64'(cur.rise));
          checkOutput("wl_line", 64'(wl), 64'(1) << cur.rowIdx);
          checkOutput("row_out", 64'(row), 64'(cur.rowIdx));
          checkOutput("bl_at_rise", 64'(bl), 64'(cur.data));
        end
        for (int r = 0; r < NWL; r++) if (wl[r]) bank[r] = bl;
      end
      if (prevWl != '0 && wl == '0) begin
        checkOutput("wl_width", 64'(cyc - riseCyc), 64'(P));
        checkOutput("bl_at_fall", 64'(bl), 64'(cur.data));
      end
      if (done) begin
        if (doneQ.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'd0);
        end else begin
          checkOutput("done_cycle", 64'(cyc), 64'(doneQ.pop_front()));
        end
      end
      prevWl = wl;
    end
    prevBl = bl;
  end

  task automatic startPass();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rowCnt = 0;
  endtask

  // Offer one row; entered and left at a negedge. The expected pulse follows
  // from the acceptance edge alone: wl rises S edges later, and after the
  // last row done follows S+P+H edges after acceptance.
  task automatic applyStimulus(input logic [7:0] d);
    exp_t e;
    int   acc;
    bit   ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 100; t++) begin
      if (in_ready) begin
        acc = cyc + 1;
        e.rowIdx = rowCnt;
        e.data   = d;
        e.rise   = acc + S;
        expQ.push_back(e);
        if (rowCnt == NWL - 1) doneQ.push_back(acc + S + P + H);
        passData[rowCnt] = d;
        rowCnt++;
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitReady();
    for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
    checkOutput("wait_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic randomPass();
    startPass();
    for (int r = 0; r < NWL; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(8'($urandom));
    end
    repeat (8) @(negedge clk);
    for (int r = 0; r < NWL; r++)
      checkOutput("bank_readback", 64'(bank[r]), 64'(passData[r]));
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_bl", 64'(bl), 64'd0);
  endtask

  int accC, riseC, doneC, highC, doneCnt;

  initial begin
    for (int r = 0; r < NWL; r++) bank[r] = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_bl", 64'(bl), 64'd0);
    checkOutput("rst_wl", 64'(wl), 64'd0);
    checkOutput("rst_row", 64'(row), 64'd0);
    checkOutput("rst_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Pass 1: rows 0x01..0x08, start/in_valid noise while busy, a gap after row 3.
    startPass();
    checkOutput("pass_busy", 64'(busy), 64'd1);
    for (int r = 0; r < NWL; r++) begin
      applyStimulus(8'(r + 1));
      if (r == 1) begin
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hEE;
        repeat (3) @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        checkOutput("ignore_start_row", 64'(row), 64'd1);
        checkOutput("ignore_start_bl", 64'(bl), 64'd2);
      end
      if (r == 3) begin
        waitReady();
        repeat (10) begin
          checkOutput("gap_ready", 64'(in_ready), 64'd1);
          checkOutput("gap_wl", 64'(wl), 64'd0);
          checkOutput("gap_row", 64'(row), 64'd4);
          @(negedge clk);
        end
      end
    end
    repeat (8) @(negedge clk);
    for (int r = 0; r < NWL; r++)
      checkOutput("bank_readback", 64'(bank[r]), 64'(r + 1));

    // Pass 2: reset while row 5 is pulsing.
    startPass();
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(8'($urandom));
    end
    for (int t = 0; t < 20 && !wl[5]; t++) @(negedge clk);
    checkOutput("row5_pulse", 64'(wl), 64'h20);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_wl", 64'(wl), 64'd0);
    checkOutput("midrst_bl", 64'(bl), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_row", 64'(row), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    checkOutput("midrst_queue", 64'(expQ.size()), 64'd0);

    // Fresh randomised passes after the interrupted one.
    randomPass();
    randomPass();

    // Single-row instance: S=3, P=1, H=2, data 0xA5.
    @(negedge clk);
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    c_valid = 1'b1;
    c_data  = 8'hA5;
    accC = -1;
    for (int t = 0; t < 10 && accC < 0; t++) begin
      if (c_ready) accC = cyc + 1;
      else @(negedge clk);
    end
    checkOutput("c_accept", 64'(accC >= 0), 64'd1);
    @(posedge clk);
    #1 c_valid = 1'b0;
    riseC = -1; doneC = -1; highC = 0; doneCnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (c_wl[0]) begin
        if (riseC < 0) begin
          riseC = cyc;
          checkOutput("c_bl_at_rise", 64'(c_bl), 64'hA5);
        end
        highC++;
      end
      if (c_done) begin
        if (doneC < 0) doneC = cyc;
        doneCnt++;
      end
    end
    checkOutput("c_rise_delay", 64'(riseC - accC), 64'd3);
    checkOutput("c_wl_width", 64'(highC), 64'd1);
    checkOutput("c_done_delay", 64'(doneC - accC), 64'd6);
    checkOutput("c_done_count", 64'(doneCnt), 64'd1);
    checkOutput("c_idle_bl", 64'(c_bl), 64'd0);
    checkOutput("c_idle_busy", 64'(c_busy), 64'd0);

    checkOutput("exp_queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("done_queue_empty", 64'(doneQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global time limit so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, got no end, expected end");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "[TB] timeout");
  end

endmodule
